// File: rtl/amo_pkg.sv
// Shared encodings for the RV32A atomic sequencer: request opcodes, one-hot
// ALU opcodes and the sequencer state type.
package amo_pkg;

  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;

  localparam logic [15:0] ALU_ADD  = 16'd1;
  localparam logic [15:0] ALU_XOR  = 16'd4;
  localparam logic [15:0] ALU_OR   = 16'd8;
  localparam logic [15:0] ALU_AND  = 16'd16;
  localparam logic [15:0] ALU_SWAP = 16'd8192;
  localparam logic [15:0] ALU_MAX  = 16'd16384;
  localparam logic [15:0] ALU_MIN  = 16'd32768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_RESP
  } state_e;

  function automatic logic is_amo(input logic [3:0] op);
    return (op >= OP_SWAP) && (op <= OP_MAXU);
  endfunction

  // MIN/MAX reuse the unsigned comparator through a sign-bit bias.
  function automatic logic is_signed_cmp(input logic [3:0] op);
    return (op == OP_MIN) || (op == OP_MAX);
  endfunction

endpackage

// File: rtl/amo_reservation.sv
// Single LR/SC reservation for the hart: a valid bit plus the reserved address.
module amo_reservation #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              clear,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              valid,
  output logic              match
);

  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (set) begin
      valid <= 1'b1;
      addr  <= set_addr;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  always_comb begin
    match = valid && (addr == cmp_addr);
  end

endmodule

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: read old word, compute on the shared ALU, write back,
// return the old word; also arbitrates LR/SC through the reservation.
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] SIGNED_BIAS = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       alu_v1,
  output logic [31:0]       alu_v2,
  output logic [15:0]       alu_op,
  input  logic [63:0]       alu_result
);

  state_e            state, state_n;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       old_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              bad_req;
  logic              sc_ok;
  logic              res_set;
  logic              res_clear;
  logic              res_valid;
  logic              res_match;
  logic              unused_alu_hi;

  assign unused_alu_hi = ^alu_result[63:32];
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

  amo_reservation #(
    .ADDR_W(ADDR_W)
  ) u_reservation (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (res_set),
    .clear   (res_clear),
    .set_addr(addr_q),
    .cmp_addr(req_addr),
    .valid   (res_valid),
    .match   (res_match)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    bad_req = (req_addr[1:0] != 2'b00) || (req_op > OP_MAXU);
    sc_ok   = res_valid && res_match;
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    alu_op     = '0;
    alu_v1     = '0;
    alu_v2     = '0;
    res_set    = 1'b0;
    res_clear  = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = rst_n;
        accept    = req_valid && rst_n;
        if (accept) begin
          if (bad_req) begin
            state_n = S_RESP;
          end else if (req_op == OP_SC) begin
            // SC consumes the reservation whether it succeeds or fails.
            res_clear = 1'b1;
            state_n   = sc_ok ? S_WRITE : S_RESP;
          end else begin
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (op_q == OP_LR) begin
            res_set = 1'b1;
            state_n = S_RESP;
          end else begin
            state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_v1 = old_q;
        alu_v2 = data_q;
        unique case (op_q)
          OP_SWAP: alu_op = ALU_SWAP;
          OP_ADD:  alu_op = ALU_ADD;
          OP_XOR:  alu_op = ALU_XOR;
          OP_AND:  alu_op = ALU_AND;
          OP_OR:   alu_op = ALU_OR;
          OP_MINU: alu_op = ALU_MIN;
          OP_MAXU: alu_op = ALU_MAX;
          OP_MIN: begin
            alu_op = ALU_MIN;
            alu_v1 = old_q ^ SIGNED_BIAS;
            alu_v2 = data_q ^ SIGNED_BIAS;
          end
          OP_MAX: begin
            alu_op = ALU_MAX;
            alu_v1 = old_q ^ SIGNED_BIAS;
            alu_v2 = data_q ^ SIGNED_BIAS;
          end
          default: alu_op = '0;
        endcase
        state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          res_clear = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      old_q     <= '0;
      wdata_q   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            data_q   <= req_data;
            resp_err <= 1'b0;
            if (bad_req) begin
              resp_err  <= 1'b1;
              resp_data <= '0;
            end else if (req_op == OP_SC) begin
              if (sc_ok) begin
                wdata_q <= req_data;
              end else begin
                resp_data <= 32'd1;
              end
            end
          end
        end
        S_READ: begin
          if (mem_ack) begin
            old_q <= mem_rdata;
            if (op_q == OP_LR) begin
              resp_data <= mem_rdata;
            end
          end
        end
        S_EXEC: begin
          wdata_q <= alu_result[31:0] ^ (is_signed_cmp(op_q) ? SIGNED_BIAS : 32'h0);
        end
        S_WRITE: begin
          if (mem_ack) begin
            resp_data <= (op_q == OP_SC) ? 32'h0 : old_q;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Sequences RV32A atomic instructions (LR.W, SC.W, AMO*.W) between the core's memory stage, the data-memory port and the shared combinational ALU.
- Per operation: read the old word, compute the new word on the ALU with its one-hot opcode, write it back, return the old word.
- Sits beside the load/store unit and owns the ALU only while it is in its EXEC state.
- Holds the single LR/SC reservation for the hart.

Parameters:
- ADDR_W, 32, byte-address width of requests and the memory port.
- SIGNED_BIAS, 32'h8000_0000, XOR bias that maps signed MIN/MAX onto the ALU's unsigned compare.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  core presents an atomic request
- req_ready  output  1  sequencer accepts the request (IDLE only)
- req_op  input  4  0 LR, 1 SC, 2 SWAP, 3 ADD, 4 XOR, 5 AND, 6 OR, 7 MIN, 8 MAX, 9 MINU, 10 MAXU; 11-15 illegal
- req_addr  input  ADDR_W  word address (byte granularity)
- req_data  input  32  rs2 operand
- resp_valid  output  1  result available
- resp_ready  input  1  core consumes the result
- resp_data  output  32  old memory word (LR/AMO), or 0 = SC success / 1 = SC fail
- resp_err  output  1  misaligned address or illegal op; no memory access performed
- mem_req  output  1  memory access request, held until mem_ack
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  access address
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid with mem_ack on a read
- mem_ack  input  1  access completes this cycle
- alu_v1  output  32  ALU operand 1
- alu_v2  output  32  ALU operand 2
- alu_op  output  16  one-hot ALU opcode
- alu_result  input  64  ALU output; bits [31:0] are used

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset state: IDLE; req_ready=0 during reset; resp_valid, resp_err, mem_req, mem_we = 0; alu_op = 0; alu_v1/alu_v2/mem_addr/mem_wdata/resp_data = 0; reservation invalid.
- Reset mid-operation: abort immediately to IDLE. An in-flight mem_req drops and the memory side must tolerate this.
- States: IDLE, READ, EXEC, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op/addr/data.
  - If addr[1:0]!=0 or op>10: go to RESP with resp_err=1 and resp_data=0.
  - LR or AMO: go to READ.
  - SC with reservation valid and reserved address == addr: go to WRITE with wdata=req_data.
  - SC otherwise: go to RESP with resp_data=1 and no memory access.
- READ: mem_req=1, mem_we=0. Stay until mem_ack; then latch old=mem_rdata.
  - LR: set reservation (valid, addr), go to RESP with resp_data=old.
  - AMO: go to EXEC.
- EXEC: exactly one cycle. Drive the ALU and register the new word = alu_result[31:0] (XOR SIGNED_BIAS for MIN/MAX). Go to WRITE.
- ALU mapping in EXEC, as alu_op / v1 / v2:
  - SWAP: 8192, old, data.
  - ADD: 1, old, data.
  - XOR: 4, old, data.
  - AND: 16, old, data.
  - OR: 8, old, data.
  - MINU: 32768, old, data.
  - MAXU: 16384, old, data.
  - MIN: 32768, old^SIGNED_BIAS, data^SIGNED_BIAS.
  - MAX: 16384, old^SIGNED_BIAS, data^SIGNED_BIAS.
- ALU idle: outside EXEC, alu_op=0 and alu_v1/alu_v2 hold 0. Only alu_result[31:0] is used; the upper 32 bits are ignored.
- WRITE: mem_req=1, mem_we=1, mem_wdata = new word (AMO) or req_data (SC). Stay until mem_ack, then go to RESP.
  - resp_data = old (AMO) or 0 (SC).
  - Any write clears the reservation.
- SC outcome: an SC clears the reservation whether it succeeds or fails.
- RESP: resp_valid=1 with resp_data/resp_err stable until resp_ready. On the handshake cycle go to IDLE and clear resp_valid/resp_err.
  - No back-to-back accept: req_ready is 0 in RESP.
- mem_ack: ignored outside READ/WRITE. mem_addr/mem_we/mem_wdata stay stable while mem_req=1.
- Latency (acks same cycle, resp_ready=1): measured from the accept edge to resp_valid high.
  - AMO: 4 cycles (READ, EXEC, WRITE, RESP).
  - LR: 2 cycles.
  - SC success: 2 cycles.
  - SC fail or error: 1 cycle.
- Wait states extend READ/WRITE one cycle per stall.

Decomposition:
- Shared package amo_pkg:
  - req_op encodings.
  - ALU one-hot opcode constants: ALU_ADD=1, ALU_XOR=4, ALU_OR=8, ALU_AND=16, ALU_SWAP=8192, ALU_MAX=16384, ALU_MIN=32768.
  - State encoding.
- Natural sub-module: amo_reservation. It holds the valid bit and address, and takes set, clear and match-compare inputs.
- Op-to-ALU mapping stays inline in amo_sequencer.

Test Plan:
- AMOADD: mem[0x100]=5, req_op=3, data=7, zero-wait acks → resp_data=5, resp_valid 4 cycles after accept, write of 12 to 0x100, alu_op=1 only in EXEC.
- Signed AMOMIN vs MINU: mem=0xFFFF_FFFE, data=3.
  - op=7 → writes 0xFFFF_FFFE.
  - op=9 → writes 3.
  - Both return 0xFFFF_FFFE.
- LR/SC pair: LR 0x200 (mem=9) → resp 9. SC 0x200 data=4 → write 4, resp 0. Second SC 0x200 → no mem_req, resp 1.
- SC after intervening AMO: LR 0x300, then AMOSWAP 0x300, then SC 0x300 → SC resp 1, no write.
- Errors: req_addr=0x102 or req_op=12 → resp_err=1, resp_data=0, mem_req never asserted.
- Stalls and reset:
  - mem_ack delayed 3 cycles in READ → mem_req/mem_addr held stable, response delayed 3.
  - rst_n=0 in WRITE → next cycle IDLE, mem_req=0, a following SC fails.
